sar_adc_ctrl: RTL

//   Parametrised successive-approximation ADC controller. Drives an external DAC
//   and analog mux, and samples an external comparator. Resolves one bit per

---
 rtl/sar_adc_if.sv | 25 ++
 rtl/sar_adc_ctrl.sv | 111 +++++++++++
 2 files changed

// File: rtl/sar_adc_if.sv
// sar_adc_if: bundles the sar_adc_ctrl request, analog front-end and result signals.
// master = controller side: takes start/ch_sel/cmp_in and drives dac_code/mux_sel/busy/data_out/data_ch/valid.
// slave  = environment side: the request source, the comparator and the result consumer.
interface sar_adc_if #(
  parameter int WIDTH = 8,
  parameter int CH_W  = 2
);
  logic             start;
  logic [CH_W-1:0]  ch_sel;
  logic             cmp_in;
  logic [WIDTH-1:0] dac_code;
  logic [CH_W-1:0]  mux_sel;
  logic             busy;
  logic [WIDTH-1:0] data_out;
  logic [CH_W-1:0]  data_ch;
  logic             valid;
  modport master (
    input  start, ch_sel, cmp_in,
    output dac_code, mux_sel, busy, data_out, data_ch, valid
  );
  modport slave (
    output start, ch_sel, cmp_in,
    input  dac_code, mux_sel, busy, data_out, data_ch, valid
  );
endinterface

// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl: successive-approximation ADC controller, one bit per SETTLE-cycle trial, MSB first.
// Ports: clk, rst (async, active-high), bus (sar_adc_if.master): start/ch_sel request,
//   cmp_in comparator, dac_code/mux_sel to the analog front end, busy, data_out/data_ch/valid result.
// Option: define SAR_ADC_AVG_EN to average 4 conversions per accepted start.
module sar_adc_ctrl #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int SETTLE = 2
) (
  input logic       clk,
  input logic       rst,
  sar_adc_if.master bus
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int BW   = $clog2(WIDTH);
  localparam int SW   = SETTLE > 1 ? $clog2(SETTLE) : 1;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] TRIAL = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};
  logic [1:0]       state;
  logic [BW-1:0]    bit_idx;
  logic [SW-1:0]    settle_cnt;
  logic [WIDTH-1:0] dac_code, next_code, data_out;
  logic [CH_W-1:0]  mux_sel, data_ch, ch_clip;
  logic             busy, valid, last;
  assign ch_clip = 32'(bus.ch_sel) >= NUM_CH ? CH_W'(NUM_CH - 1) : bus.ch_sel;
  assign last    = settle_cnt == SW'(SETTLE - 1);
  // Resolve the current bit from the comparator and tentatively set the next lower one.
  always_comb begin
    next_code = dac_code;
    next_code[bit_idx] = dac_code[bit_idx] & bus.cmp_in;
    if (bit_idx != '0) next_code[bit_idx - 1'b1] = 1'b1;
  end
`ifdef SAR_ADC_AVG_EN
  logic [WIDTH+1:0] acc, acc_sum;
  logic [1:0]       avg_cnt;
  assign acc_sum = acc + {2'b00, dac_code};
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      bit_idx    <= '0;
      settle_cnt <= '0;
      dac_code   <= '0;
      mux_sel    <= '0;
      busy       <= 1'b0;
      data_out   <= '0;
      data_ch    <= '0;
      valid      <= 1'b0;
`ifdef SAR_ADC_AVG_EN
      acc        <= '0;
      avg_cnt    <= '0;
`endif
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE:
          if (bus.start) begin
            busy       <= 1'b1;
            mux_sel    <= ch_clip;
            dac_code   <= MSB;
            bit_idx    <= BW'(WIDTH - 1);
            settle_cnt <= '0;
            state      <= TRIAL;
`ifdef SAR_ADC_AVG_EN
            acc        <= '0;
            avg_cnt    <= '0;
`endif
          end
        TRIAL:
          if (last) begin
            dac_code   <= next_code;
            settle_cnt <= '0;
            if (bit_idx == '0) state <= DONE;
            else bit_idx <= bit_idx - 1'b1;
          end else settle_cnt <= settle_cnt + 1'b1;
        DONE:
`ifdef SAR_ADC_AVG_EN
          if (avg_cnt != 2'd3) begin
            acc      <= acc_sum;
            avg_cnt  <= avg_cnt + 1'b1;
            dac_code <= MSB;
            bit_idx  <= BW'(WIDTH - 1);
            state    <= TRIAL;
          end else begin
            data_out <= acc_sum[WIDTH+1:2];
            data_ch  <= mux_sel;
            valid    <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
`else
          begin
            data_out <= dac_code;
            data_ch  <= mux_sel;
            valid    <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
`endif
        default: state <= IDLE;
      endcase
    end
  assign bus.dac_code = dac_code;
  assign bus.mux_sel  = mux_sel;
  assign bus.busy     = busy;
  assign bus.data_out = data_out;
  assign bus.data_ch  = data_ch;
  assign bus.valid    = valid;
endmodule
